// File: rtl/float_pkg.sv
// float_pkg: IEEE-754 single-precision field layout, numeric constants and
// the operand classification shared by the float_to_int converter and the
// upstream floor stage.
package float_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_W   = 23;
  localparam int EXP_W    = EXP_MSB - EXP_LSB + 1;

  localparam logic [EXP_W-1:0] EXP_BIAS    = 8'd127;
  localparam logic [EXP_W-1:0] EXP_MAX     = 8'd255;
  localparam logic [EXP_W-1:0] INT_BIG_EXP = 8'd158;

  // Operand classes as seen by an integer conversion. SMALL covers zero and
  // denormals as well as any magnitude below 1.0; BIG is |x| >= 2^31.
  typedef enum logic [2:0] {
    NAN    = 3'd0,
    INF    = 3'd1,
    BIG    = 3'd2,
    SMALL  = 3'd3,
    NORMAL = 3'd4
  } fclass_e;

  function automatic fclass_e classify(input logic [EXP_W-1:0] e,
                                       input logic [FRAC_W-1:0] f);
    fclass_e c;
    if (e == EXP_MAX) begin
      c = (f != '0) ? NAN : INF;
    end else if (e < EXP_BIAS) begin
      c = SMALL;
    end else if (e >= INT_BIG_EXP) begin
      c = BIG;
    end else begin
      c = NORMAL;
    end
    return c;
  endfunction

endpackage

// File: rtl/float_to_int_shifter.sv
// float_to_int_shifter: combinational alignment of the 24-bit mantissa to an
// integer magnitude for an unbiased exponent k in 0..30. Left shift for
// k >= 23, right shift (truncation) otherwise. When FLOAT_TO_INT_FLAGS_EN is
// defined a sticky bit reports whether any 1 was shifted out.
module float_to_int_shifter
  import float_pkg::*;
(
  input  logic [FRAC_W:0] mant,
  input  logic [4:0]      k,
  output logic [31:0]     mag
`ifdef FLOAT_TO_INT_FLAGS_EN
  ,
  output logic            sticky
`endif
);

  logic [4:0] lsh;
  logic [4:0] rsh;

  // Pick the shift direction; the magnitude never reaches bit 31 for k <= 30.
  always_comb begin
    lsh = k - 5'(FRAC_W);
    rsh = 5'(FRAC_W) - k;
    if (k >= 5'(FRAC_W)) begin
      mag = {8'd0, mant} << lsh;
    end else begin
      mag = {8'd0, mant >> rsh};
    end
  end

`ifdef FLOAT_TO_INT_FLAGS_EN
  logic [FRAC_W:0] drop_mask;

  // Any set bit below the binary point means the truncation lost information.
  always_comb begin
    drop_mask = ({{FRAC_W{1'b0}}, 1'b1} << rsh) - {{FRAC_W{1'b0}}, 1'b1};
    sticky    = (k < 5'(FRAC_W)) && ((mant & drop_mask) != '0);
  end
`endif

endmodule

// File: rtl/float_to_int.sv
// float_to_int: pipelined IEEE-754 single -> signed 32-bit integer converter,
// truncating toward zero, with saturation and a fixed NaN code.
// Stages: S1 decode/classify, S2 mantissa shift, S3 sign/saturate result.
// All stages share one advance signal, so a stalled consumer freezes the
// whole pipe and in_ready simply mirrors that advance.
// Build macro FLOAT_TO_INT_FLAGS_EN adds the out_invalid/out_inexact outputs.
module float_to_int
  import float_pkg::*;
#(
  parameter logic [31:0] NAN_RESULT = 32'h8000_0000,
  parameter logic [31:0] POS_SAT    = 32'h7FFF_FFFF,
  parameter logic [31:0] NEG_SAT    = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_a,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_z,
  output logic        out_valid,
  input  logic        out_ready
`ifdef FLOAT_TO_INT_FLAGS_EN
  ,
  output logic        out_invalid,
  output logic        out_inexact
`endif
);

  logic adv;

  logic            s1_valid_d, s1_valid_q;
  logic            s1_sign_d,  s1_sign_q;
  logic [4:0]      s1_k_d,     s1_k_q;
  logic [FRAC_W:0] s1_mant_d,  s1_mant_q;
  fclass_e         s1_class_d, s1_class_q;

  logic            s2_valid_d, s2_valid_q;
  logic            s2_sign_d,  s2_sign_q;
  fclass_e         s2_class_d, s2_class_q;
  logic [31:0]     s2_mag_d,   s2_mag_q;

  logic            out_valid_d, out_valid_q;
  logic [31:0]     out_z_d,     out_z_q;

  logic [31:0]     sh_mag;
  logic [31:0]     result;

`ifdef FLOAT_TO_INT_FLAGS_EN
  logic            sh_sticky;
  logic            s1_nonzero_d,  s1_nonzero_q;
  logic            s2_nonzero_d,  s2_nonzero_q;
  logic            s2_sticky_d,   s2_sticky_q;
  logic            out_invalid_d, out_invalid_q;
  logic            out_inexact_d, out_inexact_q;
`endif

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_z     = out_z_q;
  assign out_valid = out_valid_q;
`ifdef FLOAT_TO_INT_FLAGS_EN
  assign out_invalid = out_invalid_q;
  assign out_inexact = out_inexact_q;
`endif

  float_to_int_shifter u_shifter (
    .mant   (s1_mant_q),
    .k      (s1_k_q),
    .mag    (sh_mag)
`ifdef FLOAT_TO_INT_FLAGS_EN
    ,
    .sticky (sh_sticky)
`endif
  );

  // Final integer from class, sign and aligned magnitude.
  always_comb begin
    case (s2_class_q)
      NAN:      result = NAN_RESULT;
      INF, BIG: result = s2_sign_q ? NEG_SAT : POS_SAT;
      SMALL:    result = 32'd0;
      default:  result = s2_sign_q ? (32'd0 - s2_mag_q) : s2_mag_q;
    endcase
  end

  // Next state for all stages; everything holds unless the pipe advances,
  // and out_z only changes when a valid item lands in the output stage.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_k_d      = s1_k_q;
    s1_mant_d   = s1_mant_q;
    s1_class_d  = s1_class_q;
    s2_valid_d  = s2_valid_q;
    s2_sign_d   = s2_sign_q;
    s2_class_d  = s2_class_q;
    s2_mag_d    = s2_mag_q;
    out_valid_d = out_valid_q;
    out_z_d     = out_z_q;
`ifdef FLOAT_TO_INT_FLAGS_EN
    s1_nonzero_d  = s1_nonzero_q;
    s2_nonzero_d  = s2_nonzero_q;
    s2_sticky_d   = s2_sticky_q;
    out_invalid_d = out_invalid_q;
    out_inexact_d = out_inexact_q;
`endif
    if (adv) begin
      // S1: the low five bits of e minus the bias give k modulo 32, which
      // is exact over the NORMAL exponent range 127..157.
      s1_valid_d = in_valid;
      s1_sign_d  = in_a[SIGN_BIT];
      s1_k_d     = in_a[EXP_LSB+4:EXP_LSB] - EXP_BIAS[4:0];
      s1_mant_d  = {1'b1, in_a[FRAC_W-1:0]};
      s1_class_d = classify(in_a[EXP_MSB:EXP_LSB], in_a[FRAC_W-1:0]);

      s2_valid_d = s1_valid_q;
      s2_sign_d  = s1_sign_q;
      s2_class_d = s1_class_q;
      s2_mag_d   = sh_mag;

      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        out_z_d = result;
      end
`ifdef FLOAT_TO_INT_FLAGS_EN
      s1_nonzero_d = (in_a[EXP_MSB:0] != '0);
      s2_nonzero_d = s1_nonzero_q;
      s2_sticky_d  = sh_sticky;
      if (s2_valid_q) begin
        out_invalid_d = (s2_class_q == NAN) || (s2_class_q == INF) ||
                        (s2_class_q == BIG);
        out_inexact_d = ((s2_class_q == SMALL) && s2_nonzero_q) ||
                        ((s2_class_q == NORMAL) && s2_sticky_q);
      end
`endif
    end
  end

  // Pipeline registers; reset empties the pipe and clears all data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_k_q      <= '0;
      s1_mant_q   <= '0;
      s1_class_q  <= NAN;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_class_q  <= NAN;
      s2_mag_q    <= '0;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
`ifdef FLOAT_TO_INT_FLAGS_EN
      s1_nonzero_q  <= 1'b0;
      s2_nonzero_q  <= 1'b0;
      s2_sticky_q   <= 1'b0;
      out_invalid_q <= 1'b0;
      out_inexact_q <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_k_q      <= s1_k_d;
      s1_mant_q   <= s1_mant_d;
      s1_class_q  <= s1_class_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_class_q  <= s2_class_d;
      s2_mag_q    <= s2_mag_d;
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
`ifdef FLOAT_TO_INT_FLAGS_EN
      s1_nonzero_q  <= s1_nonzero_d;
      s2_nonzero_q  <= s2_nonzero_d;
      s2_sticky_q   <= s2_sticky_d;
      out_invalid_q <= out_invalid_d;
      out_inexact_q <= out_inexact_d;
`endif
    end
  end

endmodule

// File: tb/tb_float_to_int.sv
// tb_float_to_int: self-checking bench for float_to_int. Expected results are
// queued when an input is accepted and compared when the output transfers.
// Honours FLOAT_TO_INT_FLAGS_EN to also check out_invalid/out_inexact.
`timescale 1ns/1ps
module tb_float_to_int;

  localparam logic [31:0] POS_SAT = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_SAT = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_a;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_z;
  logic        out_valid;
  logic        out_ready;
`ifdef FLOAT_TO_INT_FLAGS_EN
  logic        out_invalid;
  logic        out_inexact;
`endif

  float_to_int dut (
    .clk         (clk),
    .rst         (rst),
    .in_a        (in_a),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_z       (out_z),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
`ifdef FLOAT_TO_INT_FLAGS_EN
    ,
    .out_invalid (out_invalid),
    .out_inexact (out_inexact)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] z;
    logic        inv;
    logic        inx;
    logic        lat_chk;
    int          acc_cyc;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] z;
    logic        inv;
    logic        inx;
  } vec_t;

  exp_t sb[$];
  exp_t drv_exp;
  logic lat_en = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   stall_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: pop and compare on each output transfer, then record a newly
  // accepted input. Signals are stable at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    exp_t n;
    if (rst === 1'b0) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL spurious_output: got %h want none", out_z);
        end else begin
          e = sb.pop_front();
          checkOutput("out_z", out_z, e.z);
`ifdef FLOAT_TO_INT_FLAGS_EN
          checkOutput("out_invalid", {31'd0, out_invalid}, {31'd0, e.inv});
          checkOutput("out_inexact", {31'd0, out_inexact}, {31'd0, e.inx});
`endif
          if (e.lat_chk) checkOutput("latency", cyc - e.acc_cyc, 32'd3);
        end
      end
      if (in_valid && in_ready) begin
        n = drv_exp;
        n.acc_cyc = cyc;
        sb.push_back(n);
      end
    end
  end

  // Present one item and hold it until accepted; leaves us 1ns after the edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] z,
                               input logic inv, input logic inx);
    int waits;
    waits = 0;
    in_a = a;
    in_valid = 1'b1;
    drv_exp.z = z;
    drv_exp.inv = inv;
    drv_exp.inx = inx;
    drv_exp.lat_chk = lat_en;
    drv_exp.acc_cyc = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (waits > 0) stall_cnt++;
    if (!in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 want 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 60) begin
      w++;
      idle(1);
    end
    checkOutput("drain", sb.size(), 32'd0);
  endtask

  vec_t vecs [21];

  initial begin : main
    logic        s;
    int          e;
    logic [22:0] f;
    logic [63:0] d;
    logic [31:0] fb;
    logic [31:0] ez;
    logic        einv;
    real         x;
    real         y;
    int          w;

    vecs = '{
      '{32'h40490FDB, 32'h00000003, 1'b0, 1'b1},
      '{32'hC0490FDB, 32'hFFFFFFFD, 1'b0, 1'b1},
      '{32'h3F000000, 32'h00000000, 1'b0, 1'b1},
      '{32'h80000000, 32'h00000000, 1'b0, 1'b0},
      '{32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{32'hCF000000, 32'h80000000, 1'b1, 1'b0},
      '{32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0},
      '{32'hCEFFFFFF, 32'h80000080, 1'b0, 1'b0},
      '{32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{32'hFF800000, 32'h80000000, 1'b1, 1'b0},
      '{32'h7FC00000, 32'h80000000, 1'b1, 1'b0},
      '{32'hFFC00001, 32'h80000000, 1'b1, 1'b0},
      '{32'h3FC00000, 32'h00000001, 1'b0, 1'b1},
      '{32'h40000000, 32'h00000002, 1'b0, 1'b0},
      '{32'h00000001, 32'h00000000, 1'b0, 1'b1},
      '{32'h3F800000, 32'h00000001, 1'b0, 1'b0},
      '{32'hBF800000, 32'hFFFFFFFF, 1'b0, 1'b0},
      '{32'h4B000001, 32'h00800001, 1'b0, 1'b0},
      '{32'h4B7FFFFF, 32'h00FFFFFF, 1'b0, 1'b0},
      '{32'h3F7FFFFF, 32'h00000000, 1'b0, 1'b1},
      '{32'h4AFFFFFF, 32'h007FFFFF, 1'b0, 1'b1}
    };

    rst = 1'b1;
    in_a = 32'd0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #12;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_out_z", out_z, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] streaming table vectors");
    out_ready = 1'b1;
    lat_en = 1'b1;
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].a, vecs[i].z, vecs[i].inv, vecs[i].inx);
      if (i == 5 || i == 12) idle(1);
    end
    drain();

    $display("[TB] backpressure");
    lat_en = 1'b0;
    fork
      begin
        applyStimulus(32'h3F800000, 32'd1, 1'b0, 1'b0);
        applyStimulus(32'h40000000, 32'd2, 1'b0, 1'b0);
        applyStimulus(32'h40400000, 32'd3, 1'b0, 1'b0);
        applyStimulus(32'h40800000, 32'd4, 1'b0, 1'b0);
      end
      begin : hold_blk
        int hw;
        hw = 0;
        do begin
          @(posedge clk);
          #1;
          hw++;
        end while (!out_valid && hw < 20);
        if (!out_valid) begin
          total++;
          bad++;
          $display("[TB] FAIL bp_first_valid: got out_valid=0 want 1");
        end
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
          checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
          checkOutput("bp_out_z_hold", out_z, 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] reset mid-flight");
    applyStimulus(32'h40A00000, 32'd5, 1'b0, 1'b0);
    applyStimulus(32'h40C00000, 32'd6, 1'b0, 1'b0);
    rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_out_z", out_z, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    w = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) w++;
    end
    checkOutput("midrst_ghost_outputs", w, 32'd0);
    @(posedge clk);
    #1;

    // Stand-in for the floor stage: floor the random value in real
    // arithmetic and feed the resulting single-precision bits.
    $display("[TB] floor-fed random run");
    lat_en = 1'b1;
    stall_cnt = 0;
    for (int n = 0; n < 5000; n++) begin
      s = 1'($urandom_range(0, 1));
      e = $urandom_range(110, 165);
      f = 23'($urandom());
      d = {s, 11'(e + 896), f, 29'd0};
      x = $bitstoreal(d);
      y = $floor(x);
      d = $realtobits(y);
      if (d[62:52] == 11'd0) fb = {d[63], 31'd0};
      else fb = {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
      if (y >= 2147483648.0) begin
        ez = POS_SAT;
        einv = 1'b1;
      end else if (y <= -2147483648.0) begin
        ez = NEG_SAT;
        einv = 1'b1;
      end else begin
        ez = $rtoi(y);
        einv = 1'b0;
      end
      applyStimulus(fb, ez, einv, 1'b0);
    end
    drain();
    checkOutput("throughput_stalls", stall_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
